// File: rtl/control_sequencer.sv
// Hardwired control unit: walks fetch (T0-T2) and execute (T3-T7) for each instruction
// and drives datapath, memory, ALU and register-select strobes as Moore outputs.
module control_sequencer #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        CONin,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [3:0]  alu_op,
  output logic [3:0]  state_dbg
);

  localparam int WW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(MEM_WAIT - 1);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BRX  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_PAUSE = 4'd9,
    S_HALT  = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_IMM, C_LD, C_ST, C_BRX, C_HALT
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR:     classify = C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  classify = C_IMM;
      OP_LD:                             classify = C_LD;
      OP_ST:                             classify = C_ST;
      OP_BRX:                            classify = C_BRX;
      OP_HALT:                           classify = C_HALT;
      default:                           classify = C_NOP;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:          alu_code = ALU_SUB;
      OP_AND, OP_ANDI: alu_code = ALU_AND;
      OP_OR,  OP_ORI:  alu_code = ALU_OR;
      default:         alu_code = ALU_ADD;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [4:0]      op_q, op_d;
  op_class_e       cls_q, cls_ir;
  state_e          boundary;

  // Register fields are decoded by the select/encode block, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[26:0];

  assign cls_q     = classify(op_q);
  assign cls_ir    = classify(IR[31:27]);
  // Every path back to T0 samples stop here; PAUSE holds the PC untouched.
  assign boundary  = stop ? S_PAUSE : S_T0;
  assign state_dbg = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
      wait_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    op_d    = op_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = WAIT_INIT;
      end
      S_T1: begin
        if (wait_q != '0) wait_d = wait_q - WW'(1);
        else              state_d = S_T2;
      end
      S_T2: begin
        op_d = IR[31:27];
        case (cls_ir)
          C_ALU, C_IMM, C_LD, C_ST, C_BRX: state_d = S_T3;
          C_HALT:                          state_d = S_HALT;
          default:                         state_d = boundary;
        endcase
      end
      S_T3: state_d = (cls_q == C_NOP || cls_q == C_HALT) ? boundary : S_T4;
      S_T4: state_d = (cls_q == C_BRX) ? boundary : S_T5;
      S_T5: begin
        if (cls_q == C_LD || cls_q == C_ST) begin
          state_d = S_T6;
          if (cls_q == C_LD) wait_d = WAIT_INIT;
        end else begin
          state_d = boundary;
        end
      end
      S_T6: begin
        if (cls_q == C_ST) begin
          state_d = S_T7;
          wait_d  = WAIT_INIT;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WW'(1);
        end else begin
          state_d = S_T7;
        end
      end
      S_T7: begin
        if (cls_q == C_ST && wait_q != '0) wait_d = wait_q - WW'(1);
        else                               state_d = boundary;
      end
      S_PAUSE: if (!stop) state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    run = 1'b0;  PCout = 1'b0;   PCin = 1'b0;  IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;  Yin = 1'b0;   Zin = 1'b0;
    Zlowout = 1'b0; Cout = 1'b0; CONin = 1'b0; Read = 1'b0;  Write = 1'b0;
    Gra = 1'b0;  Grb = 1'b0;     Grc = 1'b0;   Rin = 1'b0;   Rout = 1'b0;
    BAout = 1'b0; alu_op = 4'b0000;
    case (state_q)
      S_T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        case (cls_q)
          C_ALU:              begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_IMM, C_LD, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_BRX:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        run = 1'b1;
        case (cls_q)
          C_ALU: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_code(op_q); end
          C_IMM, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = alu_code(op_q); end
          // The only IR/flag-to-output path: branch target load gated by the condition flop.
          C_BRX: begin Grb = 1'b1; Rout = 1'b1; PCin = CON_FF; end
          default: ;
        endcase
      end
      S_T5: begin
        run = 1'b1;
        case (cls_q)
          C_ALU, C_IMM: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST:   begin Zlowout = 1'b1; MARin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        run = 1'b1;
        if (cls_q == C_ST) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else               begin Read = 1'b1; MDRin = 1'b1; end
      end
      S_T7: begin
        run = 1'b1;
        if (cls_q == C_ST) Write = 1'b1;
        else               begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one DUT with single-cycle memory, one with a 3-cycle wait.
module tb_control_sequencer;

  localparam logic [20:0] RUN     = 21'h1 << 0;
  localparam logic [20:0] PCOUT   = 21'h1 << 1;
  localparam logic [20:0] PCIN    = 21'h1 << 2;
  localparam logic [20:0] INCPC   = 21'h1 << 3;
  localparam logic [20:0] MARIN   = 21'h1 << 4;
  localparam logic [20:0] MDRIN   = 21'h1 << 5;
  localparam logic [20:0] MDROUT  = 21'h1 << 6;
  localparam logic [20:0] IRIN    = 21'h1 << 7;
  localparam logic [20:0] YIN     = 21'h1 << 8;
  localparam logic [20:0] ZIN     = 21'h1 << 9;
  localparam logic [20:0] ZLOWOUT = 21'h1 << 10;
  localparam logic [20:0] COUT    = 21'h1 << 11;
  localparam logic [20:0] CONIN   = 21'h1 << 12;
  localparam logic [20:0] READ    = 21'h1 << 13;
  localparam logic [20:0] WRITE   = 21'h1 << 14;
  localparam logic [20:0] GRA     = 21'h1 << 15;
  localparam logic [20:0] GRB     = 21'h1 << 16;
  localparam logic [20:0] GRC     = 21'h1 << 17;
  localparam logic [20:0] RIN     = 21'h1 << 18;
  localparam logic [20:0] ROUT    = 21'h1 << 19;
  localparam logic [20:0] BAOUT   = 21'h1 << 20;

  localparam logic [24:0] E_ZERO = 25'h0;
  localparam logic [24:0] E_T0   = {4'b0000, RUN | PCOUT | MARIN | INCPC | ZIN};
  localparam logic [24:0] E_T1   = {4'b0000, RUN | ZLOWOUT | PCIN | READ | MDRIN};
  localparam logic [24:0] E_T2   = {4'b0000, RUN | MDROUT | IRIN};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        CON_FF = 1'b0;
  logic        stop = 1'b0;
  logic [20:0] s1, s3;
  logic [3:0]  a1, a3;
  logic [3:0]  unused_dbg1, unused_dbg3;
  int          checks = 0;
  int          errors = 0;
  logic [24:0] exp_v [0:15];

  always #5 clock = ~clock;

  control_sequencer #(.MEM_WAIT(1)) u1 (
    .clock(clock), .reset_n(reset_n), .IR(IR), .CON_FF(CON_FF), .stop(stop),
    .run(s1[0]), .PCout(s1[1]), .PCin(s1[2]), .IncPC(s1[3]), .MARin(s1[4]),
    .MDRin(s1[5]), .MDRout(s1[6]), .IRin(s1[7]), .Yin(s1[8]), .Zin(s1[9]),
    .Zlowout(s1[10]), .Cout(s1[11]), .CONin(s1[12]), .Read(s1[13]), .Write(s1[14]),
    .Gra(s1[15]), .Grb(s1[16]), .Grc(s1[17]), .Rin(s1[18]), .Rout(s1[19]),
    .BAout(s1[20]), .alu_op(a1), .state_dbg(unused_dbg1)
  );

  control_sequencer #(.MEM_WAIT(3)) u3 (
    .clock(clock), .reset_n(reset_n), .IR(IR), .CON_FF(CON_FF), .stop(stop),
    .run(s3[0]), .PCout(s3[1]), .PCin(s3[2]), .IncPC(s3[3]), .MARin(s3[4]),
    .MDRin(s3[5]), .MDRout(s3[6]), .IRin(s3[7]), .Yin(s3[8]), .Zin(s3[9]),
    .Zlowout(s3[10]), .Cout(s3[11]), .CONin(s3[12]), .Read(s3[13]), .Write(s3[14]),
    .Gra(s3[15]), .Grb(s3[16]), .Grc(s3[17]), .Rin(s3[18]), .Rout(s3[19]),
    .BAout(s3[20]), .alu_op(a3), .state_dbg(unused_dbg3)
  );

  // Inputs change on the falling edge; the next falling edge sees the state after one rise.
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    IR = 32'h18918000;
    stop = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a1, s1} !== E_ZERO) begin
      errors++; $display("FAIL reset_u1 got %h want %h", {a1, s1}, E_ZERO);
    end
    checks++;
    if ({a3, s3} !== E_ZERO) begin
      errors++; $display("FAIL reset_u3 got %h want %h", {a3, s3}, E_ZERO);
    end
    @(negedge clock);
    reset_n = 1'b1;
    exp_v[0] = E_T0;
    exp_v[1] = E_T1;
    exp_v[2] = E_T2;
    exp_v[3] = {4'b0000, RUN | GRB | ROUT | YIN};
    exp_v[4] = {4'b0000, RUN | GRC | ROUT | ZIN};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if ({a1, s1} !== exp_v[i]) begin
        errors++; $display("FAIL reset_pre cyc%0d got %h want %h", i, {a1, s1}, exp_v[i]);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a1, s1} !== E_ZERO) begin
      errors++; $display("FAIL reset_mid_t4 got %h want %h", {a1, s1}, E_ZERO);
    end
    @(negedge clock);
    checks++;
    if ({a1, s1} !== E_ZERO) begin
      errors++; $display("FAIL reset_held got %h want %h", {a1, s1}, E_ZERO);
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({a1, s1} !== E_T0) begin
      errors++; $display("FAIL reset_release got %h want %h", {a1, s1}, E_T0);
    end
  endtask

  task automatic test_add();
    IR = 32'h18918000;
    do_reset();
    exp_v[0] = E_T0;
    exp_v[1] = E_T1;
    exp_v[2] = E_T2;
    exp_v[3] = {4'b0000, RUN | GRB | ROUT | YIN};
    exp_v[4] = {4'b0000, RUN | GRC | ROUT | ZIN};
    exp_v[5] = {4'b0000, RUN | ZLOWOUT | GRA | RIN};
    exp_v[6] = E_T0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      checks++;
      if ({a1, s1} !== exp_v[i]) begin
        errors++; $display("FAIL add cyc%0d got %h want %h", i, {a1, s1}, exp_v[i]);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] irs [0:6];
    logic [3:0]  alus [0:6];
    logic        imm [0:6];
    irs[0] = 32'h20000000; alus[0] = 4'b0001; imm[0] = 1'b0;
    irs[1] = 32'h28000000; alus[1] = 4'b0010; imm[1] = 1'b0;
    irs[2] = 32'h30000000; alus[2] = 4'b0011; imm[2] = 1'b0;
    irs[3] = 32'h60000000; alus[3] = 4'b0000; imm[3] = 1'b1;
    irs[4] = 32'h68000000; alus[4] = 4'b0010; imm[4] = 1'b1;
    irs[5] = 32'h70000000; alus[5] = 4'b0011; imm[5] = 1'b1;
    irs[6] = 32'h08000000; alus[6] = 4'b0000; imm[6] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      IR = irs[k];
      do_reset();
      exp_v[0] = E_T0;
      exp_v[1] = E_T1;
      exp_v[2] = E_T2;
      exp_v[3] = imm[k] ? {4'b0000, RUN | GRB | BAOUT | YIN} : {4'b0000, RUN | GRB | ROUT | YIN};
      exp_v[4] = imm[k] ? {alus[k], RUN | COUT | ZIN} : {alus[k], RUN | GRC | ROUT | ZIN};
      exp_v[5] = {4'b0000, RUN | ZLOWOUT | GRA | RIN};
      exp_v[6] = E_T0;
      for (int i = 0; i < 7; i++) begin
        @(negedge clock);
        checks++;
        if ({a1, s1} !== exp_v[i]) begin
          errors++; $display("FAIL alu_op%0d cyc%0d got %h want %h", k, i, {a1, s1}, exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_nop();
    logic [31:0] irs [0:1];
    irs[0] = 32'hD0000000;
    irs[1] = 32'hF8000000;
    for (int k = 0; k < 2; k++) begin
      IR = irs[k];
      do_reset();
      exp_v[0] = E_T0;
      exp_v[1] = E_T1;
      exp_v[2] = E_T2;
      exp_v[3] = E_T0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clock);
        checks++;
        if ({a1, s1} !== exp_v[i]) begin
          errors++; $display("FAIL nop%0d cyc%0d got %h want %h", k, i, {a1, s1}, exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back_brx();
    IR = 32'h92B00000;
    CON_FF = 1'b1;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      exp_v[0] = E_T0;
      exp_v[1] = E_T1;
      exp_v[2] = E_T2;
      exp_v[3] = {4'b0000, RUN | GRA | ROUT | CONIN};
      exp_v[4] = (pass == 0) ? {4'b0000, RUN | GRB | ROUT | PCIN} : {4'b0000, RUN | GRB | ROUT};
      for (int i = 0; i < 5; i++) begin
        @(negedge clock);
        checks++;
        if ({a1, s1} !== exp_v[i]) begin
          errors++; $display("FAIL brx%0d cyc%0d got %h want %h", pass, i, {a1, s1}, exp_v[i]);
        end
      end
      CON_FF = 1'b0;
    end
    @(negedge clock);
    checks++;
    if ({a1, s1} !== E_T0) begin
      errors++; $display("FAIL brx_end got %h want %h", {a1, s1}, E_T0);
    end
  endtask

  task automatic test_pause();
    IR = 32'h18918000;
    stop = 1'b0;
    do_reset();
    exp_v[0] = E_T0;
    exp_v[1] = E_T1;
    exp_v[2] = E_T2;
    exp_v[3] = {4'b0000, RUN | GRB | ROUT | YIN};
    exp_v[4] = {4'b0000, RUN | GRC | ROUT | ZIN};
    exp_v[5] = {4'b0000, RUN | ZLOWOUT | GRA | RIN};
    exp_v[6] = E_ZERO;
    exp_v[7] = E_ZERO;
    exp_v[8] = E_T0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      checks++;
      if ({a1, s1} !== exp_v[i]) begin
        errors++; $display("FAIL pause cyc%0d got %h want %h", i, {a1, s1}, exp_v[i]);
      end
      stop = (i >= 5 && i < 7);
    end
    stop = 1'b0;
  endtask

  task automatic test_ld_wait();
    IR = 32'h02000010;
    do_reset();
    exp_v[0]  = E_T0;
    exp_v[1]  = E_T1;
    exp_v[2]  = E_T1;
    exp_v[3]  = E_T1;
    exp_v[4]  = E_T2;
    exp_v[5]  = {4'b0000, RUN | GRB | BAOUT | YIN};
    exp_v[6]  = {4'b0000, RUN | COUT | ZIN};
    exp_v[7]  = {4'b0000, RUN | ZLOWOUT | MARIN};
    exp_v[8]  = {4'b0000, RUN | READ | MDRIN};
    exp_v[9]  = {4'b0000, RUN | READ | MDRIN};
    exp_v[10] = {4'b0000, RUN | READ | MDRIN};
    exp_v[11] = {4'b0000, RUN | MDROUT | GRA | RIN};
    exp_v[12] = E_T0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      checks++;
      if ({a3, s3} !== exp_v[i]) begin
        errors++; $display("FAIL ld_wait cyc%0d got %h want %h", i, {a3, s3}, exp_v[i]);
      end
    end
  endtask

  task automatic test_st_wait();
    IR = 32'h10000000;
    do_reset();
    exp_v[0]  = E_T0;
    exp_v[1]  = E_T1;
    exp_v[2]  = E_T1;
    exp_v[3]  = E_T1;
    exp_v[4]  = E_T2;
    exp_v[5]  = {4'b0000, RUN | GRB | BAOUT | YIN};
    exp_v[6]  = {4'b0000, RUN | COUT | ZIN};
    exp_v[7]  = {4'b0000, RUN | ZLOWOUT | MARIN};
    exp_v[8]  = {4'b0000, RUN | GRA | ROUT | MDRIN};
    exp_v[9]  = {4'b0000, RUN | WRITE};
    exp_v[10] = {4'b0000, RUN | WRITE};
    exp_v[11] = {4'b0000, RUN | WRITE};
    exp_v[12] = E_T0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      checks++;
      if ({a3, s3} !== exp_v[i]) begin
        errors++; $display("FAIL st_wait cyc%0d got %h want %h", i, {a3, s3}, exp_v[i]);
      end
    end
  endtask

  task automatic test_halt();
    IR = 32'hD8000000;
    do_reset();
    exp_v[0] = E_T0;
    exp_v[1] = E_T1;
    exp_v[2] = E_T2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({a1, s1} !== exp_v[i]) begin
        errors++; $display("FAIL halt_fetch cyc%0d got %h want %h", i, {a1, s1}, exp_v[i]);
      end
    end
    stop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if ({a1, s1} !== E_ZERO) begin
        errors++; $display("FAIL halt_hold cyc%0d got %h want %h", i, {a1, s1}, E_ZERO);
      end
      stop = ~stop;
    end
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_nop();
    test_back_to_back_brx();
    test_pause();
    test_ld_wait();
    test_st_wait();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
